// File: rtl/vector_alu_checker.sv
// Scoreboard for an N-lane ALU: predicts each lane's result, delays it
// LAT cycles and compares it with Z, keeping counters and a first-error record.
module vector_alu_checker #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [N*WIDTH-1:0]            A,
  input  logic [N*WIDTH-1:0]            B,
  input  logic [3*N-1:0]                sel,
  input  logic [N-1:0]                  enable,
  input  logic [N*2*WIDTH-1:0]          Z,
  input  logic                          clear,
  output logic [31:0]                   chk_cnt,
  output logic [15:0]                   err_cnt,
  output logic [N-1:0]                  err_lane,
  output logic [15:0]                   skip_cnt,
  output logic                          first_vld,
  output logic [((N>1)?$clog2(N):1)-1:0] first_idx,
  output logic [2:0]                    first_sel,
  output logic [2*WIDTH-1:0]            first_exp,
  output logic [2*WIDTH-1:0]            first_act,
  output logic                          pass
);

  localparam int W2 = 2 * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  function automatic logic [W2-1:0] alu(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [W2-1:0] a2, b2;
    a2 = W2'(a);
    b2 = W2'(b);
    case (op)
      3'd0:    alu = a2 + b2;
      3'd1:    alu = a2 - b2;
      3'd2:    alu = a2 & b2;
      3'd3:    alu = a2 | b2;
      3'd4:    alu = a2 * b2;
      3'd5:    alu = (b2 == '0) ? '0 : a2 / b2;
      default: alu = '0;
    endcase
  endfunction

  logic [N*W2-1:0] exp_in;
  logic [N-1:0]    vld_in, skp_in;

  always_comb begin
    exp_in = '0;
    vld_in = '0;
    skp_in = '0;
    for (int i = 0; i < N; i++) begin
      logic [2:0] op;
      logic       ok;
      op = sel[i*3 +: 3];
      ok = (op <= 3'd5) &&
           !(op == 3'd5 && B[i*WIDTH +: WIDTH] == '0);
      exp_in[i*W2 +: W2] = alu(A[i*WIDTH +: WIDTH],
                               B[i*WIDTH +: WIDTH], op);
      vld_in[i] = enable[i] && ok;
      skp_in[i] = enable[i] && !ok;
    end
  end

  logic [LAT-1:0][N*W2-1:0] exp_d, exp_q;
  logic [LAT-1:0][3*N-1:0]  sel_d, sel_q;
  logic [LAT-1:0][N-1:0]    vld_d, vld_q;

  always_comb begin
    exp_d    = exp_q;
    sel_d    = sel_q;
    vld_d    = vld_q;
    exp_d[0] = exp_in;
    sel_d[0] = sel;
    vld_d[0] = vld_in;
    for (int k = 1; k < LAT; k++) begin
      exp_d[k] = exp_q[k-1];
      sel_d[k] = sel_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
  end

  logic [N-1:0]    mis;
  int unsigned     nchk, nerr, nskp;
  logic [IW-1:0]   fidx;
  logic [2:0]      fsel;
  logic [W2-1:0]   fexp, fact;

  always_comb begin
    mis  = '0;
    nchk = 0;
    nerr = 0;
    nskp = 0;
    fidx = '0;
    fsel = '0;
    fexp = '0;
    fact = '0;
    for (int i = 0; i < N; i++) begin
      mis[i] = vld_q[LAT-1][i] &&
               (exp_q[LAT-1][i*W2 +: W2] != Z[i*W2 +: W2]);
      if (vld_q[LAT-1][i]) nchk = nchk + 1;
      if (mis[i])          nerr = nerr + 1;
      if (skp_in[i])       nskp = nskp + 1;
    end
    // Walk downward so the lowest mismatching lane is the one kept
    for (int i = N - 1; i >= 0; i--) begin
      if (mis[i]) begin
        fidx = IW'(i);
        fsel = sel_q[LAT-1][i*3 +: 3];
        fexp = exp_q[LAT-1][i*W2 +: W2];
        fact = Z[i*W2 +: W2];
      end
    end
  end

  logic [31:0]   chk_cnt_d, chk_cnt_q;
  logic [15:0]   err_cnt_d, err_cnt_q;
  logic [15:0]   skip_cnt_d, skip_cnt_q;
  logic [N-1:0]  err_lane_d, err_lane_q;
  logic          first_vld_d, first_vld_q;
  logic [IW-1:0] first_idx_d, first_idx_q;
  logic [2:0]    first_sel_d, first_sel_q;
  logic [W2-1:0] first_exp_d, first_exp_q;
  logic [W2-1:0] first_act_d, first_act_q;
  logic          pass_d, pass_q;
  logic [32:0]   chk_sum;
  logic [16:0]   err_sum, skp_sum;

  always_comb begin
    chk_sum     = {1'b0, chk_cnt_q} + 33'(nchk);
    err_sum     = {1'b0, err_cnt_q} + 17'(nerr);
    skp_sum     = {1'b0, skip_cnt_q} + 17'(nskp);
    chk_cnt_d   = chk_sum[32] ? '1 : chk_sum[31:0];
    err_cnt_d   = err_sum[16] ? '1 : err_sum[15:0];
    skip_cnt_d  = skp_sum[16] ? '1 : skp_sum[15:0];
    err_lane_d  = err_lane_q | mis;
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;
    first_sel_d = first_sel_q;
    first_exp_d = first_exp_q;
    first_act_d = first_act_q;
    if (!first_vld_q && (mis != '0)) begin
      first_vld_d = 1'b1;
      first_idx_d = fidx;
      first_sel_d = fsel;
      first_exp_d = fexp;
      first_act_d = fact;
    end
    if (clear) begin
      chk_cnt_d   = '0;
      err_cnt_d   = '0;
      skip_cnt_d  = '0;
      err_lane_d  = '0;
      first_vld_d = 1'b0;
      first_idx_d = '0;
      first_sel_d = '0;
      first_exp_d = '0;
      first_act_d = '0;
    end
    pass_d = (chk_cnt_d != '0) && (err_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      exp_q       <= '0;
      sel_q       <= '0;
      vld_q       <= '0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      err_lane_q  <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
      first_sel_q <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      exp_q       <= exp_d;
      sel_q       <= sel_d;
      vld_q       <= vld_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      err_lane_q  <= err_lane_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
      first_sel_q <= first_sel_d;
      first_exp_q <= first_exp_d;
      first_act_q <= first_act_d;
      pass_q      <= pass_d;
    end
  end

  assign chk_cnt   = chk_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign skip_cnt  = skip_cnt_q;
  assign err_lane  = err_lane_q;
  assign first_vld = first_vld_q;
  assign first_idx = first_idx_q;
  assign first_sel = first_sel_q;
  assign first_exp = first_exp_q;
  assign first_act = first_act_q;
  assign pass      = pass_q;

endmodule

// File: doc/vector_alu_checker.md
VECTOR_ALU_CHECKER -- requirements
Module: vector_alu_checker

Interface
REQ-001 Parameter N, default 4: number of ALU lanes checked.
REQ-002 Parameter WIDTH, default 8: operand width; results are 2*WIDTH.
REQ-003 Parameter LAT, default 1: DUT latency in cycles from operand sample to Z valid; legal range 1..8.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 arst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 A  in  WIDTH x N  lane operand A, same bus as DUT input.
REQ-007 B  in  WIDTH x N  lane operand B.
REQ-008 sel  in  3 x N  lane opcode: 0 add, 1 sub, 2 and, 3 or, 4 mul, 5 div.
REQ-009 enable  in  N  per-lane enable, same bus as DUT input.
REQ-010 Z  in  2*WIDTH x N  DUT lane results.
REQ-011 clear  in  1  synchronous clear of counters, flags and first-error capture.
REQ-012 chk_cnt  out  32  number of lane comparisons performed, saturating.
REQ-013 err_cnt  out  16  number of lane mismatches, saturating.
REQ-014 err_lane  out  N  sticky per-lane mismatch flag.
REQ-015 skip_cnt  out  16  lanes skipped (div by zero or opcode 6/7), saturating.
REQ-016 first_vld  out  1  first-error record valid.
REQ-017 first_idx  out  $clog2(N), min 1  lane index of the first mismatch.
REQ-018 first_sel, first_exp, first_act  out  3, 2*WIDTH, 2*WIDTH  opcode, expected and actual Z of the first mismatch.
REQ-019 pass  out  1  high when chk_cnt>0 and err_cnt==0.

Function
REQ-020 Each cycle, per lane, compute expected result from A, B and sel, and a check-valid bit = enable[i] and opcode legal and not skipped.
REQ-021 Expected result, zero-extended to 2*WIDTH: add A+B; sub (A-B) mod 2^(2*WIDTH); and A&B; or A|B; mul full unsigned product; div unsigned floor(A/B).
REQ-022 div with B==0 and opcode 6/7 with enable=1 make the lane skipped: no comparison; skip_cnt increments by one per such lane.
REQ-023 Lanes with enable=0 are neither checked nor counted.
REQ-024 Expected values, opcodes and check-valid bits pass through a LAT-stage register pipeline; the stage-LAT output is compared with Z in the same cycle.
REQ-025 A mismatch is a valid lane whose expected value differs from Z; err_lane[i] sets and stays set until clear or reset.
REQ-026 chk_cnt increments by the number of valid lanes per cycle; err_cnt increments by the number of mismatching lanes per cycle; both saturate at all-ones without wrapping.
REQ-027 On the first mismatch since reset/clear, first_* capture the lowest-index mismatching lane and first_vld sets; later mismatches do not overwrite the capture.
REQ-028 clear takes priority: in a cycle with clear=1, all counters, err_lane, first_vld and first_* go to 0 and that cycle's comparison and skip results are discarded; the pipeline is not flushed.
REQ-029 All outputs are registered; the counter and flag effects of a comparison appear one cycle after the comparison edge.

Reset
REQ-030 While arst=0: all pipeline check-valid bits, counters, err_lane, first_vld and first_* are 0; pass is 0.
REQ-031 After arst deasserts mid-operation, no comparison occurs until operands sampled after reset reach stage LAT (LAT cycles).

Verification
REQ-032 LAT=1, lane0 add A=200 B=100 enable=0001, Z0=300 next cycle -> chk_cnt=1, err_cnt=0, pass=1.
REQ-033 Lane1 sub A=5 B=7, Z1=16'hFFFE -> no error; Z1=16'h00FE -> err_cnt=1, err_lane=0010, first_idx=1, first_exp=16'hFFFE, first_act=16'h00FE.
REQ-034 All lanes mul A=255 B=255 with Z=65025, and lanes 2 and 3 with Z=0 in one cycle -> err_cnt+=2, first_idx=2, err_lane=1100.
REQ-035 Div B=0 on lane3 and sel=7 on lane0 -> skip_cnt+=2, chk_cnt unchanged, no error.
REQ-036 Preload err_cnt near 16'hFFFF with repeated mismatches -> holds 16'hFFFF; clear coincident with a mismatch -> all counters 0, first_vld=0.
REQ-037 arst low for 3 cycles mid-stream -> outputs 0 during reset; first check occurs LAT cycles after release.
